// File: rtl/dds_sweep.sv
// Frequency-sweep controller for the DDS tuning word: steps linearly between a
// start and stop word, dwelling either a number of clocks or DDS output periods.
module dds_sweep #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start_i,
  input  logic                   Abort_i,
  input  logic [1:0]             Mode_i,
  input  logic [7:0]             StartWord_i,
  input  logic [7:0]             StopWord_i,
  input  logic [7:0]             Step_i,
  input  logic [DWELL_WIDTH-1:0] Dwell_i,
  input  logic                   CountPeriods_i,
  input  logic                   Overflow_i,
  output logic [7:0]             TuningWord_o,
  output logic                   Busy_o,
  output logic                   Done_o,
  output logic                   Direction_o
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  state_t                 r_state, w_state_nxt;
  mode_t                  r_mode, w_mode_nxt;
  logic [7:0]             r_start, w_start_nxt;
  logic [7:0]             r_stop, w_stop_nxt;
  logic [7:0]             r_step, w_step_nxt;
  logic [DWELL_WIDTH-1:0] r_dwell, w_dwell_nxt;
  logic                   r_periods, w_periods_nxt;
  logic [DWELL_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]             r_word, w_word_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_dir, w_dir_nxt;

  logic [DWELL_WIDTH-1:0] w_dwell_eff;
  logic                   w_advance;
  logic                   w_expire;
  logic [8:0]             w_up;
  logic [8:0]             w_dn;
  logic                   w_up_ok;
  logic                   w_dn_ok;

  // A programmed dwell of zero behaves as one.
  assign w_dwell_eff = (r_dwell == '0) ? DWELL_WIDTH'(1) : r_dwell;
  assign w_advance   = r_periods ? Overflow_i : 1'b1;
  assign w_expire    = w_advance && (r_cnt == w_dwell_eff - DWELL_WIDTH'(1));

  // Nine-bit sums expose the carry/borrow so an overshoot never wraps around.
  assign w_up    = {1'b0, r_word} + {1'b0, r_step};
  assign w_dn    = {1'b0, r_word} - {1'b0, r_step};
  assign w_up_ok = (w_up <= {1'b0, r_stop});
  assign w_dn_ok = !w_dn[8] && (w_dn[7:0] >= r_start);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_mode    <= MODE_SINGLE;
      r_start   <= '0;
      r_stop    <= '0;
      r_step    <= '0;
      r_dwell   <= '0;
      r_periods <= 1'b0;
      r_cnt     <= '0;
      r_word    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dir     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_start   <= w_start_nxt;
      r_stop    <= w_stop_nxt;
      r_step    <= w_step_nxt;
      r_dwell   <= w_dwell_nxt;
      r_periods <= w_periods_nxt;
      r_cnt     <= w_cnt_nxt;
      r_word    <= w_word_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_dir     <= w_dir_nxt;
    end
  end

  always_comb begin
    // NOTE: every next value defaults to "hold" before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_start_nxt   = r_start;
    w_stop_nxt    = r_stop;
    w_step_nxt    = r_step;
    w_dwell_nxt   = r_dwell;
    w_periods_nxt = r_periods;
    w_cnt_nxt     = r_cnt;
    w_word_nxt    = r_word;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_dir_nxt     = r_dir;

    if (Abort_i) begin
      w_state_nxt = IDLE;
      w_word_nxt  = '0;
      w_busy_nxt  = 1'b0;
      w_dir_nxt   = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (Start_i) begin
            w_mode_nxt    = mode_t'(Mode_i);
            w_start_nxt   = StartWord_i;
            w_stop_nxt    = StopWord_i;
            w_step_nxt    = Step_i;
            w_dwell_nxt   = Dwell_i;
            w_periods_nxt = CountPeriods_i;
            w_word_nxt    = StartWord_i;
            w_dir_nxt     = 1'b0;
            w_cnt_nxt     = '0;
            if (Step_i == 8'd0 || StartWord_i > StopWord_i) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = DWELL;
              w_busy_nxt  = 1'b1;
            end
          end
        end
        DWELL: begin
          if (w_expire) begin
            w_cnt_nxt = '0;
            if (!r_dir) begin
              if (w_up_ok) begin
                w_word_nxt = w_up[7:0];
              end else begin
                unique case (r_mode)
                  MODE_SAW: w_word_nxt = r_start;
                  MODE_TRI: begin
                    w_dir_nxt = 1'b1;
                    if (w_dn_ok) w_word_nxt = w_dn[7:0];
                  end
                  default: begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                  end
                endcase
              end
            end else begin
              if (w_dn_ok) begin
                w_word_nxt = w_dn[7:0];
              end else begin
                w_dir_nxt = 1'b0;
                if (w_up_ok) w_word_nxt = w_up[7:0];
              end
            end
          end else if (w_advance) begin
            w_cnt_nxt = r_cnt + DWELL_WIDTH'(1);
          end
        end
        DONE: w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign TuningWord_o = r_word;
  assign Busy_o       = r_busy;
  assign Done_o       = r_done;
  assign Direction_o  = r_dir;

endmodule

// File: tb/tb_dds_sweep.sv
// Self-checking bench for dds_sweep: directed sweeps from the test plan plus
// randomized configurations, compared every cycle against an arithmetic model.
module tb_dds_sweep;

  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Start_i = 1'b0;
  logic          Abort_i = 1'b0;
  logic [1:0]    Mode_i = '0;
  logic [7:0]    StartWord_i = '0;
  logic [7:0]    StopWord_i = '0;
  logic [7:0]    Step_i = '0;
  logic [DW-1:0] Dwell_i = '0;
  logic          CountPeriods_i = 1'b0;
  logic          Overflow_i = 1'b0;
  logic [7:0]    TuningWord_o;
  logic          Busy_o;
  logic          Done_o;
  logic          Direction_o;

  int n_total = 0;
  int n_bad   = 0;
  int cyc_cnt = 0;
  int ovf_period = 0;
  bit ovf_rand = 0;

  dds_sweep #(.DWELL_WIDTH(DW)) dut (
    .Clock(Clock), .Reset(Reset), .Start_i(Start_i), .Abort_i(Abort_i),
    .Mode_i(Mode_i), .StartWord_i(StartWord_i), .StopWord_i(StopWord_i),
    .Step_i(Step_i), .Dwell_i(Dwell_i), .CountPeriods_i(CountPeriods_i),
    .Overflow_i(Overflow_i), .TuningWord_o(TuningWord_o), .Busy_o(Busy_o),
    .Done_o(Done_o), .Direction_o(Direction_o)
  );

  always #5 Clock = ~Clock;

  // Reference model: sweep rules in plain integer arithmetic, no bit widths.
  int m_word, m_dir, m_busy, m_done, m_held;
  int c_mode, c_start, c_stop, c_step, c_dwell, c_per;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_word = 0; m_dir = 0; m_busy = 0; m_done = 0; m_held = 0;
      c_mode = 0; c_start = 0; c_stop = 0; c_step = 0; c_dwell = 0; c_per = 0;
    end else if (Abort_i) begin
      m_word = 0; m_dir = 0; m_busy = 0; m_done = 0; m_held = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_busy == 0) begin
      if (Start_i) begin
        c_mode  = (int'(Mode_i) == 3) ? 0 : int'(Mode_i);
        c_start = int'(StartWord_i);
        c_stop  = int'(StopWord_i);
        c_step  = int'(Step_i);
        c_dwell = (Dwell_i == 0) ? 1 : int'(Dwell_i);
        c_per   = int'(CountPeriods_i);
        m_word = c_start; m_dir = 0; m_held = 0;
        if (c_step == 0 || c_start > c_stop) m_done = 1;
        else m_busy = 1;
      end
    end else begin
      if (c_per == 0 || Overflow_i) m_held++;
      if (m_held >= c_dwell) begin
        int up, dn;
        m_held = 0;
        up = m_word + c_step;
        dn = m_word - c_step;
        if (m_dir == 0) begin
          if (up <= c_stop) m_word = up;
          else if (c_mode == 1) m_word = c_start;
          else if (c_mode == 2) begin
            m_dir = 1;
            if (dn >= c_start) m_word = dn;
          end else begin
            m_busy = 0; m_done = 1;
          end
        end else begin
          if (dn >= c_start) m_word = dn;
          else begin
            m_dir = 0;
            if (up <= c_stop) m_word = up;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      check("word", int'(TuningWord_o), m_word);
      check("busy", int'(Busy_o), m_busy);
      check("done", int'(Done_o), m_done);
      check("dir", int'(Direction_o), m_dir);
      cyc_cnt++;
      if (ovf_period > 0) Overflow_i = ((cyc_cnt % ovf_period) == 0);
      else if (ovf_rand) Overflow_i = ($urandom_range(0, 2) == 0);
      else Overflow_i = 1'b0;
    end
  endtask

  task automatic start(input int mode, input int sw, input int pw, input int st,
                       input int dw, input int per);
    Mode_i = 2'(mode); StartWord_i = 8'(sw); StopWord_i = 8'(pw);
    Step_i = 8'(st); Dwell_i = DW'(dw); CountPeriods_i = per[0];
    Start_i = 1'b1;
    cyc(1);
    Start_i = 1'b0;
    // Configuration must only matter on the accepting edge.
    Mode_i = 2'($urandom); StartWord_i = 8'($urandom); StopWord_i = 8'($urandom);
    Step_i = 8'($urandom); Dwell_i = DW'($urandom); CountPeriods_i = 1'($urandom);
  endtask

  task automatic abort_with_start();
    Abort_i = 1'b1; Start_i = 1'b1;
    cyc(1);
    Abort_i = 1'b0; Start_i = 1'b0;
    check("abort_word", int'(TuningWord_o), 0);
    check("abort_busy", int'(Busy_o), 0);
    cyc(1);
    check("abort_nodone", int'(Done_o), 0);
  endtask

  initial begin
    int tri_exp [7] = '{10, 20, 30, 20, 10, 20, 30};
    int tri_dir [7] = '{0, 0, 0, 1, 1, 0, 0};
    int saw_exp [6] = '{0, 100, 200, 0, 100, 200};

    #12;
    check("reset_word", int'(TuningWord_o), 0);
    check("reset_busy", int'(Busy_o), 0);
    Reset = 1'b1;
    cyc(2);

    // Single ramp, clock mode
    start(0, 10, 30, 10, 4, 0);
    check("single_w0", int'(TuningWord_o), 10);
    check("single_busy", int'(Busy_o), 1);
    cyc(4); check("single_w1", int'(TuningWord_o), 20);
    cyc(4); check("single_w2", int'(TuningWord_o), 30);
    cyc(3); check("single_pre_done", int'(Done_o), 0);
    cyc(1);
    check("single_done", int'(Done_o), 1);
    check("single_busy_low", int'(Busy_o), 0);
    cyc(1);
    check("single_done_pulse", int'(Done_o), 0);
    check("single_hold", int'(TuningWord_o), 30);
    cyc(3);

    // Triangle, with an ignored Start while busy
    start(2, 10, 30, 10, 1, 0);
    for (int i = 0; i < 7; i++) begin
      check("tri_word", int'(TuningWord_o), tri_exp[i]);
      check("tri_dir", int'(Direction_o), tri_dir[i]);
      check("tri_nodone", int'(Done_o), 0);
      if (i == 2) begin
        StartWord_i = 8'd99; StopWord_i = 8'd200; Step_i = 8'd1; Start_i = 1'b1;
      end
      cyc(1);
      Start_i = 1'b0;
    end
    cyc(5);
    abort_with_start();
    cyc(2);

    // Sawtooth with a step that does not divide the range
    start(1, 0, 250, 100, 2, 0);
    for (int i = 0; i < 6; i++) begin
      check("saw_word", int'(TuningWord_o), saw_exp[i]);
      cyc(2);
    end
    abort_with_start();

    // Period mode: overflow every 5 clocks, dwell of 3 periods
    ovf_period = 5;
    cyc_cnt = 0;
    start(0, 10, 40, 10, 3, 1);
    cyc(14);
    check("period_hold", int'(TuningWord_o), 10);
    cyc(60);
    ovf_period = 0;

    // Boundaries: step 0, start above stop, dwell 0
    start(0, 5, 50, 0, 3, 0);
    check("step0_done", int'(Done_o), 1);
    check("step0_busy", int'(Busy_o), 0);
    check("step0_word", int'(TuningWord_o), 5);
    cyc(2);
    start(1, 60, 50, 3, 3, 0);
    check("inv_done", int'(Done_o), 1);
    check("inv_word", int'(TuningWord_o), 60);
    cyc(2);
    start(0, 5, 8, 1, 0, 0);
    cyc(1); check("dwell0_w1", int'(TuningWord_o), 6);
    cyc(6);

    // Asynchronous reset mid-sweep, then a normal restart
    start(2, 20, 90, 7, 2, 0);
    cyc(9);
    #2 Reset = 1'b0;
    #1;
    check("rst_word", int'(TuningWord_o), 0);
    check("rst_busy", int'(Busy_o), 0);
    check("rst_dir", int'(Direction_o), 0);
    Reset = 1'b1;
    cyc(2);
    start(0, 1, 4, 1, 1, 0);
    check("restart_word", int'(TuningWord_o), 1);
    cyc(6);

    // Randomized configurations with random overflow, starts and aborts
    ovf_rand = 1;
    for (int t = 0; t < 40; t++) begin
      int lo = $urandom_range(0, 200);
      start($urandom_range(0, 3), lo,
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(lo, 255),
            ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 90),
            $urandom_range(0, 4), $urandom_range(0, 1));
      for (int c = 0; c < 60; c++) begin
        Start_i = ($urandom_range(0, 15) == 0);
        Abort_i = ($urandom_range(0, 49) == 0);
        cyc(1);
        Start_i = 1'b0;
        Abort_i = 1'b0;
      end
      Abort_i = 1'b1;
      cyc(1);
      Abort_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
